// File: rtl/mem_access_ctrl_pkg.sv
// Shared codes for the load/store sequencer: access sizes,
// FSM states, target regions and default region bases.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [31:0] DEF_DMEM_BASE = 32'h1001_0000;
  localparam logic [31:0] DEF_VGA_BASE  = 32'hB800_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_RD,
    ST_RDATA,
    ST_MERGE,
    ST_WR
  } state_t;

  typedef enum logic [1:0] {
    RG_NONE,
    RG_DMEM,
    RG_VGA
  } region_t;

endpackage

// File: rtl/mem_access_ctrl_lane_merge.sv
// Inserts right-justified store data into the big-endian lane of an old word.
// Ports: i_old word, i_new data, i_size code, i_off byte offset -> o_merged.
module mem_access_ctrl_lane_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    case (i_size)
      SIZE_WORD: o_merged = i_new;
      SIZE_HALF: begin
        if (i_off[1]) o_merged[15:0]  = i_new[15:0];
        else          o_merged[31:16] = i_new[15:0];
      end
      SIZE_BYTE: begin
        case (i_off)
          2'd0:    o_merged[31:24] = i_new[7:0];
          2'd1:    o_merged[23:16] = i_new[7:0];
          2'd2:    o_merged[15:8]  = i_new[7:0];
          default: o_merged[7:0]   = i_new[7:0];
        endcase
      end
      default: o_merged = i_old;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store sequencer for data memory and VGA framebuffer (sync-read).
// Ports: req_* CPU handshake, resp_* completion, dmem_*/vga_* memory ports.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] VGA_BASE   = DEF_VGA_BASE,
  parameter int          VGA_WORDS  = 1024,
  localparam int DAW = $clog2(DMEM_WORDS),
  localparam int VAW = $clog2(VGA_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [31:0]    req_addr,
  input  logic [1:0]     req_size,
  input  logic           req_bitext,
  input  logic [31:0]    req_wdata,
  output logic           resp_valid,
  output logic [31:0]    resp_rdata,
  output logic           resp_err,
  output logic           dmem_en,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [31:0]    dmem_wdata,
  input  logic [31:0]    dmem_rdata,
  output logic           vga_en,
  output logic           vga_we,
  output logic [VAW-1:0] vga_addr,
  output logic [31:0]    vga_wdata,
  input  logic [31:0]    vga_rdata
);

  localparam logic [31:0] DM_BYTES = 32'(DMEM_WORDS) << 2;
  localparam logic [31:0] VG_BYTES = 32'(VGA_WORDS) << 2;

  state_t         r_state;
  region_t        r_region;
  logic [1:0]     r_size;
  logic [1:0]     r_off;
  logic           r_bitext;
  logic           r_write;
  logic [31:0]    r_wdata;
  logic           r_ready;
  logic           r_resp_valid;
  logic           r_resp_err;
  logic           r_dmem_en;
  logic           r_dmem_we;
  logic [DAW-1:0] r_dmem_addr;
  logic [31:0]    r_dmem_wdata;
  logic           r_vga_en;
  logic           r_vga_we;
  logic [VAW-1:0] r_vga_addr;
  logic [31:0]    r_vga_wdata;

  logic [31:0]    w_dm_off;
  logic [31:0]    w_vg_off;
  logic           w_in_dm;
  logic           w_in_vg;
  region_t        w_region;
  logic           w_err;
  logic [31:0]    w_sel_rdata;
  logic [31:0]    w_merged;

  // Unsigned offset compare doubles as a lower and upper bound check.
  assign w_dm_off = req_addr - DMEM_BASE;
  assign w_vg_off = req_addr - VGA_BASE;
  assign w_in_dm  = w_dm_off < DM_BYTES;
  assign w_in_vg  = w_vg_off < VG_BYTES;

  always_comb begin
    w_region = RG_NONE;
    if (w_in_dm)      w_region = RG_DMEM;
    else if (w_in_vg) w_region = RG_VGA;
    w_err = (req_size == SIZE_ILL)
         || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
         || (req_size == SIZE_HALF && req_addr[0])
         || (w_region == RG_NONE);
  end

  assign w_sel_rdata = (r_region == RG_VGA) ? vga_rdata : dmem_rdata;

  mem_access_ctrl_lane_merge u_merge (
    .i_old    (w_sel_rdata),
    .i_new    (r_wdata),
    .i_size   (r_size),
    .i_off    (r_off),
    .o_merged (w_merged)
  );

  function automatic logic [31:0] load_extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        zx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SIZE_HALF: res = zx ? {16'h0, h} : {{16{h[15]}}, h};
      SIZE_BYTE: res = zx ? {24'h0, b} : {{24{b[7]}}, b};
      default:   res = w;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_region     <= RG_NONE;
      r_size       <= SIZE_WORD;
      r_off        <= 2'b00;
      r_bitext     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_dmem_en    <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_vga_en     <= 1'b0;
      r_vga_we     <= 1'b0;
      r_vga_addr   <= '0;
      r_vga_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_dmem_en    <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_vga_en     <= 1'b0;
      r_vga_we     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ready  <= 1'b0;
            r_region <= w_region;
            r_size   <= req_size;
            r_off    <= req_addr[1:0];
            r_bitext <= req_bitext;
            r_write  <= req_write;
            r_wdata  <= req_wdata;
            if (w_in_dm) r_dmem_addr <= w_dm_off[DAW+1:2];
            if (w_in_vg) r_vga_addr  <= w_vg_off[VAW+1:2];
            if (w_err) begin
              r_state      <= ST_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_write && req_size == SIZE_WORD) begin
              // Whole-word stores skip the read and finish next cycle.
              r_state      <= ST_WR;
              r_resp_valid <= 1'b1;
              r_dmem_en    <= (w_region == RG_DMEM);
              r_dmem_we    <= (w_region == RG_DMEM);
              r_vga_en     <= (w_region == RG_VGA);
              r_vga_we     <= (w_region == RG_VGA);
              r_dmem_wdata <= req_wdata;
              r_vga_wdata  <= req_wdata;
            end else begin
              r_state   <= ST_RD;
              r_dmem_en <= (w_region == RG_DMEM);
              r_vga_en  <= (w_region == RG_VGA);
            end
          end
        end
        ST_RD: begin
          if (r_write) begin
            r_state <= ST_MERGE;
          end else begin
            r_state      <= ST_RDATA;
            r_resp_valid <= 1'b1;
          end
        end
        ST_MERGE: begin
          // Read data is live this cycle; the merged word is captured here.
          r_state      <= ST_WR;
          r_resp_valid <= 1'b1;
          r_dmem_en    <= (r_region == RG_DMEM);
          r_dmem_we    <= (r_region == RG_DMEM);
          r_vga_en     <= (r_region == RG_VGA);
          r_vga_we     <= (r_region == RG_VGA);
          r_dmem_wdata <= w_merged;
          r_vga_wdata  <= w_merged;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = (r_state == ST_RDATA)
                    ? load_extract(w_sel_rdata, r_size, r_off, r_bitext)
                    : 32'h0;
  assign dmem_en    = r_dmem_en;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign vga_en     = r_vga_en;
  assign vga_we     = r_vga_we;
  assign vga_addr   = r_vga_addr;
  assign vga_wdata  = r_vga_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, corner
// sequences and random accesses against a byte-lane reference model.
module tb_mem_access_ctrl;

  localparam logic [31:0] DB  = 32'h1001_0000;
  localparam logic [31:0] VB  = 32'hB800_0000;
  localparam int          DMW = 2048;
  localparam int          VGW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_bitext = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_en, dmem_we;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        vga_en, vga_we;
  logic [9:0]  vga_addr;
  logic [31:0] vga_wdata;
  logic [31:0] vga_rdata = '0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_bitext(req_bitext),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dmem_en(dmem_en), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .vga_en(vga_en), .vga_we(vga_we),
    .vga_addr(vga_addr), .vga_wdata(vga_wdata),
    .vga_rdata(vga_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] dm_mem [DMW];
  logic [31:0] vg_mem [VGW];
  logic [31:0] sh_dm  [DMW];
  logic [31:0] sh_vg  [VGW];

  always @(posedge clk) begin
    if (dmem_en) begin
      if (dmem_we) dm_mem[dmem_addr] <= dmem_wdata;
      else         dmem_rdata <= dm_mem[dmem_addr];
    end
    if (vga_en) begin
      if (vga_we) vg_mem[vga_addr] <= vga_wdata;
      else        vga_rdata <= vg_mem[vga_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // 0 = unmapped, 1 = data memory, 2 = framebuffer
  function automatic int region_of(input logic [31:0] a);
    longint unsigned la = a;
    if (la >= DB && la < longint'(DB) + DMW * 4) return 1;
    if (la >= VB && la < longint'(VB) + VGW * 4) return 2;
    return 0;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    if (region_of(a) == 1) return int'((a - DB) >> 2);
    return int'((a - VB) >> 2);
  endfunction

  function automatic logic [31:0] hw_word(input logic [31:0] a);
    if (region_of(a) == 1) return dm_mem[idx_of(a)];
    if (region_of(a) == 2) return vg_mem[idx_of(a)];
    return 32'h0;
  endfunction

  function automatic logic [31:0] sh_word(input logic [31:0] a);
    if (region_of(a) == 1) return sh_dm[idx_of(a)];
    if (region_of(a) == 2) return sh_vg[idx_of(a)];
    return 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    if (region_of(a) == 1) begin
      dm_mem[idx_of(a)] <= v;
      sh_dm[idx_of(a)] = v;
    end else if (region_of(a) == 2) begin
      vg_mem[idx_of(a)] <= v;
      sh_vg[idx_of(a)] = v;
    end
  endtask

  // Reference: treat the word as four big-endian bytes and pick/replace
  // the 1, 2 or 4 bytes starting at the address offset.
  function automatic void model(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [1:0]  s,
    input  logic        bx,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int nb, off, sh, rg;
    logic [31:0] mask, word, v;
    rg  = region_of(a);
    off = int'(a % 4);
    er  = (s == 2'd3) || (s == 2'd0 && off != 0) ||
          (s == 2'd1 && (off % 2) != 0) || (rg == 0);
    rd  = 32'h0;
    if (er) begin
      lat = 1;
      return;
    end
    nb   = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    sh   = 8 * (4 - off - nb);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    word = (rg == 1) ? sh_dm[idx_of(a)] : sh_vg[idx_of(a)];
    if (!w) begin
      v = (word >> sh) & mask;
      if (!bx && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      rd  = v;
      lat = 2;
    end else begin
      word = (word & ~(mask << sh)) | ((wd & mask) << sh);
      if (rg == 1) sh_dm[idx_of(a)] = word;
      else         sh_vg[idx_of(a)] = word;
      lat = (nb == 4) ? 1 : 3;
    end
  endfunction

  // Issues one access, keeps junk on req_* while busy, and reports
  // the response cycle (1-based after the accept edge; -1 on timeout).
  task automatic run_acc(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [1:0]  s,
    input  logic        bx,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output logic        saw_en,
    output logic        saw_we,
    output logic [31:0] wr_data
  );
    bit done = 0;
    rd = '0; er = 0; lat = -1; saw_en = 0; saw_we = 0; wr_data = '0;
    @(negedge clk);
    check("ready_before", {31'h0, req_ready}, 32'h1);
    req_valid = 1; req_write = w; req_addr = a;
    req_size = s; req_bitext = bx; req_wdata = wd;
    @(posedge clk);
    #1;
    req_write = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (dmem_en || vga_en) saw_en = 1;
      if (dmem_we || vga_we) begin
        saw_we = 1;
        wr_data = dmem_we ? dmem_wdata : vga_wdata;
      end
      if (resp_valid) begin
        done = 1; lat = c; rd = resp_rdata; er = resp_err;
        req_valid = 0;
      end
    end
    req_valid = 0;
    @(negedge clk);
    check("ready_after", {31'h0, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  s;
    logic        bx;
    logic [31:0] wd;
    logic [31:0] pre;
    logic [31:0] e_rd;
    logic        e_er;
    int          e_lat;
    logic [31:0] e_mem;
  } vec_t;

  vec_t tv [13];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd, wdat, a, wd, pre;
    logic        er, mer, sen, swe, w, bx;
    logic [1:0]  s;
    int          lat, mlat, sel;

    for (int i = 0; i < DMW; i++) begin
      pre = $urandom; dm_mem[i] <= pre; sh_dm[i] = pre;
    end
    for (int i = 0; i < VGW; i++) begin
      pre = $urandom; vg_mem[i] <= pre; sh_vg[i] = pre;
    end

    // Reset state
    #12;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_en", {30'h0, dmem_en, vga_en}, 32'h0);
    @(negedge clk);
    rst = 0;

    tv[0]  = '{0, 32'h1001_0001, 2'b10, 0, 32'h0,
               32'h12F4_5678, 32'hFFFF_FFF4, 0, 2, 32'h0};
    tv[1]  = '{0, 32'h1001_0002, 2'b01, 1, 32'h0,
               32'h1234_8001, 32'h0000_8001, 0, 2, 32'h0};
    tv[2]  = '{0, 32'h1001_0002, 2'b01, 0, 32'h0,
               32'h1234_8001, 32'hFFFF_8001, 0, 2, 32'h0};
    tv[3]  = '{1, 32'hB800_0003, 2'b10, 0, 32'h0000_00AB,
               32'h1122_3344, 32'h0, 0, 3, 32'h1122_33AB};
    tv[4]  = '{1, 32'h1001_0006, 2'b00, 0, 32'h5555_5555,
               32'h0, 32'h0, 1, 1, 32'h0};
    tv[5]  = '{0, 32'h0000_0000, 2'b00, 0, 32'h0,
               32'h0, 32'h0, 1, 1, 32'h0};
    tv[6]  = '{0, 32'h1001_0000, 2'b11, 0, 32'h0,
               32'h0, 32'h0, 1, 1, 32'h0};
    tv[7]  = '{1, 32'h1001_0010, 2'b00, 0, 32'hDEAD_BEEF,
               32'h0102_0304, 32'h0, 0, 1, 32'hDEAD_BEEF};
    tv[8]  = '{1, 32'h1001_0012, 2'b01, 0, 32'hFFFF_CAFE,
               32'h1122_3344, 32'h0, 0, 3, 32'h1122_CAFE};
    tv[9]  = '{0, 32'hB800_0FFC, 2'b00, 0, 32'h0,
               32'h89AB_CDEF, 32'h89AB_CDEF, 0, 2, 32'h0};
    tv[10] = '{0, 32'hB800_1000, 2'b00, 0, 32'h0,
               32'h0, 32'h0, 1, 1, 32'h0};
    tv[11] = '{0, 32'h1001_0001, 2'b01, 0, 32'h0,
               32'h0, 32'h0, 1, 1, 32'h0};
    tv[12] = '{0, 32'h1001_1FFF, 2'b10, 1, 32'h0,
               32'h0000_00F0, 32'h0000_00F0, 0, 2, 32'h0};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (!tv[i].e_er) preload(tv[i].a, tv[i].pre);
      model(tv[i].w, tv[i].a, tv[i].s, tv[i].bx, tv[i].wd, mrd, mer, mlat);
      run_acc(tv[i].w, tv[i].a, tv[i].s, tv[i].bx, tv[i].wd,
              rd, er, lat, sen, swe, wdat);
      check($sformatf("tv%0d_rdata", i), rd, tv[i].e_rd);
      check($sformatf("tv%0d_err", i), {31'h0, er}, {31'h0, tv[i].e_er});
      check($sformatf("tv%0d_lat", i), lat, tv[i].e_lat);
      check($sformatf("tv%0d_en", i), {31'h0, sen}, {31'h0, !tv[i].e_er});
      if (tv[i].w && !tv[i].e_er) begin
        check($sformatf("tv%0d_wdata", i), wdat, tv[i].e_mem);
        check($sformatf("tv%0d_mem", i), hw_word(tv[i].a), tv[i].e_mem);
      end
    end

    // Reset during the merge cycle of a byte store
    @(negedge clk);
    preload(32'h1001_0040, 32'h5566_7788);
    @(negedge clk);
    swe = 0; sen = 0;
    req_valid = 1; req_write = 1; req_addr = 32'h1001_0041;
    req_size = 2'b10; req_bitext = 0; req_wdata = 32'h0000_00EE;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    if (dmem_en) sen = 1;
    if (dmem_we || resp_valid) swe = 1;
    @(negedge clk);
    if (dmem_we || resp_valid) swe = 1;
    rst = 1;
    #1;
    check("mrst_ready", {31'h0, req_ready}, 32'h1);
    check("mrst_en_we", {28'h0, dmem_en, dmem_we, vga_en, vga_we}, 32'h0);
    check("mrst_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dmem_we || resp_valid) swe = 1;
    end
    check("mrst_read_issued", {31'h0, sen}, 32'h1);
    check("mrst_no_we_resp", {31'h0, swe}, 32'h0);
    check("mrst_mem", hw_word(32'h1001_0040), 32'h5566_7788);

    // Random accesses against the reference model
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom);
      s  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bx = 1'($urandom);
      wd = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = DB + 32'($urandom_range(0, 63));
        4: a = DB + 32'(DMW * 4 - 16) + 32'($urandom_range(0, 15));
        5, 6: a = VB + 32'($urandom_range(0, 63));
        7: a = VB + 32'(VGW * 4 - 16) + 32'($urandom_range(0, 15));
        8: a = $urandom;
        default: a = ($urandom_range(0, 1) == 0)
                   ? DB + 32'(DMW * 4) + 32'($urandom_range(0, 7))
                   : VB - 32'($urandom_range(1, 8));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b00) a[1:0] = 2'b00;
        else if (s == 2'b01) a[0] = 1'b0;
      end
      model(w, a, s, bx, wd, mrd, mer, mlat);
      run_acc(w, a, s, bx, wd, rd, er, lat, sen, swe, wdat);
      check("rnd_rdata", rd, mrd);
      check("rnd_err", {31'h0, er}, {31'h0, mer});
      check("rnd_lat", lat, mlat);
      check("rnd_en", {31'h0, sen}, {31'h0, !mer});
      check("rnd_we", {31'h0, swe}, {31'h0, (!mer && w)});
      if (!mer) check("rnd_mem", hw_word(a), sh_word(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
